// File: rtl/decode_stage_if.sv
// Bundle between the IF/ID register, the writeback stage and the ID/EX outputs of decode_stage.
// The slave modport is the decode stage; the master modport is whoever drives decode inputs.
interface decode_stage_if #(
  parameter int XLEN = 32
);
  logic            flushE;
  logic [31:0]     instrD;
  logic [XLEN-1:0] pcplus4D;
  logic            regWriteW;
  logic [4:0]      rdW;
  logic [XLEN-1:0] resultW;

  logic [4:0]      rs1D;
  logic [4:0]      rs2D;
  logic [XLEN-1:0] rd1E;
  logic [XLEN-1:0] rd2E;
  logic [XLEN-1:0] immExtE;
  logic [XLEN-1:0] pcE;
  logic [XLEN-1:0] pcplus4E;
  logic [4:0]      rs1E;
  logic [4:0]      rs2E;
  logic [4:0]      rdE;
  logic            regWriteE;
  logic            memWriteE;
  logic            branchE;
  logic            jumpE;
  logic            aluSrcE;
  logic [1:0]      resultSrcE;
  logic [2:0]      aluControlE;

  modport slave (
    input  flushE, instrD, pcplus4D, regWriteW, rdW, resultW,
    output rs1D, rs2D, rd1E, rd2E, immExtE, pcE, pcplus4E, rs1E, rs2E, rdE,
           regWriteE, memWriteE, branchE, jumpE, aluSrcE, resultSrcE, aluControlE
  );

  modport master (
    output flushE, instrD, pcplus4D, regWriteW, rdW, resultW,
    input  rs1D, rs2D, rd1E, rd2E, immExtE, pcE, pcplus4E, rs1E, rs2E, rdE,
           regWriteE, memWriteE, branchE, jumpE, aluSrcE, resultSrcE, aluControlE
  );
endinterface

// File: rtl/decode_stage.sv
// RV32I decode stage: main/ALU decode, 32x32 register file, immediate extension, ID/EX register.
// Macro DECODE_WB_BYPASS_EN: rising-edge register-file write with read bypass (else falling-edge write).
module decode_stage #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  decode_stage_if.slave   bus
);

  typedef enum logic [2:0] {IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_sel_t;
  typedef enum logic [1:0] {ALUOP_ADD, ALUOP_SUB, ALUOP_FUNCT} alu_op_t;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_IALU = 7'b0010011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_LUI  = 7'b0110111;

  logic [6:0]      w_opcode;
  logic [2:0]      w_funct3;
  logic            w_funct7b5;
  logic [4:0]      w_rs1;
  logic [4:0]      w_rs2;
  logic [4:0]      w_rd;
  logic [4:0]      w_rs1_eff;

  logic            w_reg_write;
  logic            w_mem_write;
  logic [1:0]      w_result_src;
  logic            w_branch;
  logic            w_jump;
  logic            w_alu_src;
  logic            w_force_rs1_zero;
  alu_op_t         w_alu_op;
  imm_sel_t        w_imm_sel;
  logic [2:0]      w_alu_ctrl;
  logic [XLEN-1:0] w_imm;
  logic [XLEN-1:0] w_rd1;
  logic [XLEN-1:0] w_rd2;

  logic [XLEN-1:0] r_rf [NREGS];

  logic [XLEN-1:0] r_rd1;
  logic [XLEN-1:0] r_rd2;
  logic [XLEN-1:0] r_imm;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_pcplus4;
  logic [4:0]      r_rs1;
  logic [4:0]      r_rs2;
  logic [4:0]      r_rd;
  logic            r_reg_write;
  logic            r_mem_write;
  logic            r_branch;
  logic            r_jump;
  logic            r_alu_src;
  logic [1:0]      r_result_src;
  logic [2:0]      r_alu_ctrl;

  assign w_opcode   = bus.instrD[6:0];
  assign w_funct3   = bus.instrD[14:12];
  assign w_funct7b5 = bus.instrD[30];
  assign w_rs1      = bus.instrD[19:15];
  assign w_rs2      = bus.instrD[24:20];
  assign w_rd       = bus.instrD[11:7];
  assign w_rs1_eff  = w_force_rs1_zero ? 5'd0 : w_rs1;

  assign bus.rs1D = w_rs1;
  assign bus.rs2D = w_rs2;

  always_comb begin
    w_reg_write      = 1'b0;
    w_mem_write      = 1'b0;
    w_result_src     = 2'b00;
    w_branch         = 1'b0;
    w_jump           = 1'b0;
    w_alu_src        = 1'b0;
    w_force_rs1_zero = 1'b0;
    w_alu_op         = ALUOP_ADD;
    w_imm_sel        = IMM_NONE;
    case (w_opcode)
      OP_LW:   begin w_reg_write = 1'b1; w_result_src = 2'b01; w_alu_src = 1'b1; w_imm_sel = IMM_I; end
      OP_SW:   begin w_mem_write = 1'b1; w_alu_src = 1'b1; w_imm_sel = IMM_S; end
      OP_R:    begin w_reg_write = 1'b1; w_alu_op = ALUOP_FUNCT; end
      OP_IALU: begin w_reg_write = 1'b1; w_alu_src = 1'b1; w_alu_op = ALUOP_FUNCT; w_imm_sel = IMM_I; end
      OP_BEQ:  begin w_branch = 1'b1; w_alu_op = ALUOP_SUB; w_imm_sel = IMM_B; end
      OP_JAL:  begin w_reg_write = 1'b1; w_result_src = 2'b10; w_jump = 1'b1; w_imm_sel = IMM_J; end
      // lui is computed as x0 + imm in execute
      OP_LUI:  begin w_reg_write = 1'b1; w_alu_src = 1'b1; w_force_rs1_zero = 1'b1; w_imm_sel = IMM_U; end
      default: ;
    endcase
  end

  always_comb begin
    w_alu_ctrl = 3'b000;
    case (w_alu_op)
      ALUOP_SUB:   w_alu_ctrl = 3'b001;
      ALUOP_FUNCT: begin
        case (w_funct3)
          3'b000:  w_alu_ctrl = ((w_opcode == OP_R) && w_funct7b5) ? 3'b001 : 3'b000;
          3'b010:  w_alu_ctrl = 3'b101;
          3'b110:  w_alu_ctrl = 3'b011;
          3'b111:  w_alu_ctrl = 3'b010;
          default: w_alu_ctrl = 3'b000;
        endcase
      end
      default:     w_alu_ctrl = 3'b000;
    endcase
  end

  always_comb begin
    w_imm = '0;
    case (w_imm_sel)
      IMM_I: w_imm = {{(XLEN-12){bus.instrD[31]}}, bus.instrD[31:20]};
      IMM_S: w_imm = {{(XLEN-12){bus.instrD[31]}}, bus.instrD[31:25], bus.instrD[11:7]};
      IMM_B: w_imm = {{(XLEN-13){bus.instrD[31]}}, bus.instrD[31], bus.instrD[7],
                      bus.instrD[30:25], bus.instrD[11:8], 1'b0};
      IMM_U: w_imm = {{(XLEN-32){bus.instrD[31]}}, bus.instrD[31:12], 12'b0};
      IMM_J: w_imm = {{(XLEN-21){bus.instrD[31]}}, bus.instrD[31], bus.instrD[19:12],
                      bus.instrD[20], bus.instrD[30:21], 1'b0};
      default: w_imm = '0;
    endcase
  end

`ifdef DECODE_WB_BYPASS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) r_rf[i] <= '0;
    end else if (bus.regWriteW && (bus.rdW != 5'd0)) begin
      r_rf[bus.rdW] <= bus.resultW;
    end
  end

  // The write lands on the same edge that captures ID/EX, so forward it
  always_comb begin
    if (w_rs1_eff == 5'd0)
      w_rd1 = '0;
    else if (bus.regWriteW && (bus.rdW == w_rs1_eff))
      w_rd1 = bus.resultW;
    else
      w_rd1 = r_rf[w_rs1_eff];
    if (w_rs2 == 5'd0)
      w_rd2 = '0;
    else if (bus.regWriteW && (bus.rdW == w_rs2))
      w_rd2 = bus.resultW;
    else
      w_rd2 = r_rf[w_rs2];
  end
`else
  // Falling-edge write makes the new value readable before the next rising edge
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) r_rf[i] <= '0;
    end else if (bus.regWriteW && (bus.rdW != 5'd0)) begin
      r_rf[bus.rdW] <= bus.resultW;
    end
  end

  assign w_rd1 = (w_rs1_eff == 5'd0) ? '0 : r_rf[w_rs1_eff];
  assign w_rd2 = (w_rs2 == 5'd0)     ? '0 : r_rf[w_rs2];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n || bus.flushE) begin
      r_rd1        <= '0;
      r_rd2        <= '0;
      r_imm        <= '0;
      r_pc         <= '0;
      r_pcplus4    <= '0;
      r_rs1        <= '0;
      r_rs2        <= '0;
      r_rd         <= '0;
      r_reg_write  <= 1'b0;
      r_mem_write  <= 1'b0;
      r_branch     <= 1'b0;
      r_jump       <= 1'b0;
      r_alu_src    <= 1'b0;
      r_result_src <= 2'b00;
      r_alu_ctrl   <= 3'b000;
    end else begin
      r_rd1        <= w_rd1;
      r_rd2        <= w_rd2;
      r_imm        <= w_imm;
      r_pc         <= bus.pcplus4D - XLEN'(4);
      r_pcplus4    <= bus.pcplus4D;
      r_rs1        <= w_rs1_eff;
      r_rs2        <= w_rs2;
      r_rd         <= w_rd;
      r_reg_write  <= w_reg_write;
      r_mem_write  <= w_mem_write;
      r_branch     <= w_branch;
      r_jump       <= w_jump;
      r_alu_src    <= w_alu_src;
      r_result_src <= w_result_src;
      r_alu_ctrl   <= w_alu_ctrl;
    end
  end

  assign bus.rd1E        = r_rd1;
  assign bus.rd2E        = r_rd2;
  assign bus.immExtE     = r_imm;
  assign bus.pcE         = r_pc;
  assign bus.pcplus4E    = r_pcplus4;
  assign bus.rs1E        = r_rs1;
  assign bus.rs2E        = r_rs2;
  assign bus.rdE         = r_rd;
  assign bus.regWriteE   = r_reg_write;
  assign bus.memWriteE   = r_mem_write;
  assign bus.branchE     = r_branch;
  assign bus.jumpE       = r_jump;
  assign bus.aluSrcE     = r_alu_src;
  assign bus.resultSrcE  = r_result_src;
  assign bus.aluControlE = r_alu_ctrl;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed cases then randomized instructions
// checked against an architectural register-file and decode-table model.
module tb_decode_stage;

  logic clk;
  logic rst_n;

  decode_stage_if #(.XLEN(32)) dif ();

  decode_stage #(.XLEN(32), .NREGS(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (dif)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- scoreboard state ----------------
  typedef struct packed {
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        rw;
    logic        mw;
    logic [1:0]  rs;
    logic        br;
    logic        jp;
    logic        as;
    logic [2:0]  ac;
    logic        chk_imm;
    logic        chk_as;
  } exp_t;

  localparam int EXP_W = $bits(exp_t);

  logic [EXP_W-1:0] exp_q[$];
  logic [31:0]      ref_rf [32];
  int               n_checks;
  int               n_errors;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Architectural read as seen by a decode in the same cycle as a writeback
  function automatic logic [31:0] arch_read(input logic [4:0] idx);
    if (idx == 5'd0) return 32'd0;
    if (dif.regWriteW && dif.rdW == idx) return dif.resultW;
    return ref_rf[idx];
  endfunction

  function automatic logic [31:0] sext(input logic [31:0] v, input int bits);
    logic [31:0] span;
    span = 32'd1 << bits;
    if (v[bits-1]) return v - span;
    return v;
  endfunction

  function automatic logic [2:0] alu_funct(input logic [2:0] f3, input logic sub_ok);
    if (f3 == 3'b010) return 3'b101;
    if (f3 == 3'b110) return 3'b011;
    if (f3 == 3'b111) return 3'b010;
    if (f3 == 3'b000 && sub_ok) return 3'b001;
    return 3'b000;
  endfunction

  function automatic exp_t model(input logic [31:0] instr, input logic [31:0] pc4, input logic flush);
    exp_t e;
    logic [6:0] op;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    e = '0;
    e.chk_imm = 1'b1;
    e.chk_as  = 1'b1;
    if (flush) return e;
    op    = instr[6:0];
    imm_i = sext({20'd0, instr[31:20]}, 12);
    imm_s = sext({20'd0, instr[31:25], instr[11:7]}, 12);
    imm_b = sext({19'd0, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}, 13);
    imm_j = sext({11'd0, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}, 21);
    imm_u = instr & 32'hFFFF_F000;
    e.pc  = pc4 - 32'd4;
    e.pc4 = pc4;
    e.rs1 = (op == 7'b0110111) ? 5'd0 : instr[19:15];
    e.rs2 = instr[24:20];
    e.rd  = instr[11:7];
    e.rd1 = arch_read(e.rs1);
    e.rd2 = arch_read(e.rs2);
    case (op)
      7'b0000011: begin {e.rw, e.mw, e.rs, e.br, e.jp, e.as} = 7'b1_0_01_0_0_1; e.imm = imm_i; end
      7'b0100011: begin {e.rw, e.mw, e.rs, e.br, e.jp, e.as} = 7'b0_1_00_0_0_1; e.imm = imm_s; end
      7'b0110011: begin
        {e.rw, e.mw, e.rs, e.br, e.jp, e.as} = 7'b1_0_00_0_0_0;
        e.ac = alu_funct(instr[14:12], instr[30]);
        e.chk_imm = 1'b0;
      end
      7'b0010011: begin
        {e.rw, e.mw, e.rs, e.br, e.jp, e.as} = 7'b1_0_00_0_0_1;
        e.ac = alu_funct(instr[14:12], 1'b0);
        e.imm = imm_i;
      end
      7'b1100011: begin {e.rw, e.mw, e.rs, e.br, e.jp, e.as} = 7'b0_0_00_1_0_0; e.ac = 3'b001; e.imm = imm_b; end
      7'b1101111: begin
        {e.rw, e.mw, e.rs, e.br, e.jp} = 6'b1_0_10_0_1;
        e.imm = imm_j;
        e.chk_as = 1'b0;
      end
      7'b0110111: begin {e.rw, e.mw, e.rs, e.br, e.jp, e.as} = 7'b1_0_00_0_0_1; e.imm = imm_u; end
      default: ;
    endcase
    return e;
  endfunction

  task automatic check_all(input string tag, input exp_t e);
    check_val({tag, ".rd1E"},        dif.rd1E,        e.rd1);
    check_val({tag, ".rd2E"},        dif.rd2E,        e.rd2);
    if (e.chk_imm) check_val({tag, ".immExtE"}, dif.immExtE, e.imm);
    check_val({tag, ".pcE"},         dif.pcE,         e.pc);
    check_val({tag, ".pcplus4E"},    dif.pcplus4E,    e.pc4);
    check_val({tag, ".rs1E"},        32'(dif.rs1E),   32'(e.rs1));
    check_val({tag, ".rs2E"},        32'(dif.rs2E),   32'(e.rs2));
    check_val({tag, ".rdE"},         32'(dif.rdE),    32'(e.rd));
    check_val({tag, ".regWriteE"},   32'(dif.regWriteE), 32'(e.rw));
    check_val({tag, ".memWriteE"},   32'(dif.memWriteE), 32'(e.mw));
    check_val({tag, ".branchE"},     32'(dif.branchE),   32'(e.br));
    check_val({tag, ".jumpE"},       32'(dif.jumpE),     32'(e.jp));
    if (e.chk_as) check_val({tag, ".aluSrcE"}, 32'(dif.aluSrcE), 32'(e.as));
    check_val({tag, ".resultSrcE"},  32'(dif.resultSrcE),  32'(e.rs));
    check_val({tag, ".aluControlE"}, 32'(dif.aluControlE), 32'(e.ac));
  endtask

  // ---------------- driver tasks ----------------
  // Called just after a rising edge; returns just after the next rising edge.
  task automatic step(input string tag, input logic [31:0] instr, input logic [31:0] pc4,
                      input logic flush, input logic we, input logic [4:0] rdw,
                      input logic [31:0] resw);
    exp_t e;
    dif.instrD    = instr;
    dif.pcplus4D  = pc4;
    dif.flushE    = flush;
    dif.regWriteW = we;
    dif.rdW       = rdw;
    dif.resultW   = resw;
    #1;
    check_val({tag, ".rs1D"}, 32'(dif.rs1D), 32'(instr[19:15]));
    check_val({tag, ".rs2D"}, 32'(dif.rs2D), 32'(instr[24:20]));
    e = model(instr, pc4, flush);
    exp_q.push_back(EXP_W'(e));
    if (we && rdw != 5'd0) ref_rf[rdw] = resw;
    @(posedge clk);
    #1;
    check_all(tag, exp_t'(exp_q.pop_front()));
  endtask

  task automatic mid_run_reset();
    exp_t z;
    z = '0;
    z.chk_imm = 1'b1;
    z.chk_as  = 1'b1;
    dif.instrD    = 32'h0050_0093;
    dif.pcplus4D  = 32'h104;
    dif.flushE    = 1'b0;
    dif.regWriteW = 1'b0;
    dif.rdW       = 5'd0;
    dif.resultW   = 32'd0;
    #1;
    rst_n = 1'b0;
    #1;
    check_all("async_reset", z);
    for (int i = 0; i < 32; i++) ref_rf[i] = 32'd0;
    exp_q.delete();
    @(posedge clk);
    #1;
    check_all("reset_held", z);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  logic [6:0] ops [11] = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011,
                           7'b1101111, 7'b0110111, 7'b0000000, 7'b1110011, 7'b0010111,
                           7'b1100111};

  initial begin
    exp_t z;
    logic [31:0] instr;
    logic        we;
    logic [4:0]  rdw;
    n_checks = 0;
    n_errors = 0;
    for (int i = 0; i < 32; i++) ref_rf[i] = 32'd0;
    z = '0;
    z.chk_imm = 1'b1;
    z.chk_as  = 1'b1;

    rst_n         = 1'b0;
    dif.flushE    = 1'b0;
    dif.instrD    = 32'h0050_0093;
    dif.pcplus4D  = 32'h104;
    dif.regWriteW = 1'b0;
    dif.rdW       = 5'd0;
    dif.resultW   = 32'd0;
    #2;
    check_all("reset", z);
    @(posedge clk);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // addi x1,x0,5
    step("addi", 32'h0050_0093, 32'h104, 1'b0, 1'b0, 5'd0, 32'd0);
    check_val("addi.imm5", dif.immExtE, 32'd5);
    check_val("addi.pc", dif.pcE, 32'h100);
    check_val("addi.ctl", 32'(dif.aluControlE), 32'd0);

    // write x2 and decode add x3,x2,x2 in the same cycle
    step("collide", 32'h0021_01B3, 32'h200, 1'b0, 1'b1, 5'd2, 32'hDEAD_BEEF);
    check_val("collide.rd1", dif.rd1E, 32'hDEAD_BEEF);
    check_val("collide.rd2", dif.rd2E, 32'hDEAD_BEEF);
    step("readback", 32'h0021_01B3, 32'h204, 1'b0, 1'b0, 5'd0, 32'd0);
    check_val("readback.rd1", dif.rd1E, 32'hDEAD_BEEF);

    // writes to x0 are discarded
    step("x0_wr", 32'h0000_0013, 32'h300, 1'b0, 1'b1, 5'd0, 32'h1234);
    step("x0_rd", 32'h0000_01B3, 32'h304, 1'b0, 1'b0, 5'd0, 32'd0);
    check_val("x0.rd1", dif.rd1E, 32'd0);

    // beq x1,x2,-8, then the same with a flush
    step("beq", 32'hFE20_8CE3, 32'h400, 1'b0, 1'b0, 5'd0, 32'd0);
    check_val("beq.imm", dif.immExtE, 32'hFFFF_FFF8);
    check_val("beq.ctl", 32'(dif.aluControlE), 32'd1);
    step("beq_flush", 32'hFE20_8CE3, 32'h400, 1'b1, 1'b1, 5'd5, 32'h55);
    step("flush_wr", 32'h0002_81B3, 32'h404, 1'b0, 1'b0, 5'd0, 32'd0);
    check_val("flush_wr.rd1", dif.rd1E, 32'h55);

    // jal x1,+2048 with pc wrap
    step("jal", 32'h0010_00EF, 32'h0, 1'b0, 1'b0, 5'd0, 32'd0);
    check_val("jal.imm", dif.immExtE, 32'h800);
    check_val("jal.pc", dif.pcE, 32'hFFFF_FFFC);

    // x1 written, then reset clears it
    step("x1_wr", 32'h0000_0013, 32'h500, 1'b0, 1'b1, 5'd1, 32'hCAFE_0001);
    mid_run_reset();
    step("x1_after_rst", 32'h0000_81B3, 32'h600, 1'b0, 1'b0, 5'd0, 32'd0);
    check_val("x1_after_rst.rd1", dif.rd1E, 32'd0);

    for (int n = 0; n < 400; n++) begin
      instr = $urandom;
      instr[6:0] = ops[$urandom_range(0, 10)];
      we  = ($urandom_range(0, 1) == 1);
      rdw = ($urandom_range(0, 3) == 0) ? instr[19:15] : 5'($urandom_range(0, 31));
      step("rand", instr, $urandom, ($urandom_range(0, 9) == 0), we, rdw, $urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
